// File: rtl/mc_pkg.sv
//------------------------------------------------------------------------------
// Module   : mc_pkg
// Brief    : Shared encodings for the multi-cycle MIPS control path
//            (opcodes, FSM states, ALU operand/op selects, control word).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mc_pkg;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_RWB    = 4'd3,
    S_MEMADR = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWB  = 4'd6,
    S_MEMWR  = 4'd7,
    S_IWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_HALT   = 4'd11
  } mc_state_t;

  localparam logic [1:0] c_srcb_b       = 2'd0;
  localparam logic [1:0] c_srcb_one     = 2'd1;
  localparam logic [1:0] c_srcb_imm     = 2'd2;
  localparam logic [1:0] c_srcb_imm_sl2 = 2'd3;

  localparam logic [1:0] c_aluop_add   = 2'd0;
  localparam logic [1:0] c_aluop_sub   = 2'd1;
  localparam logic [1:0] c_aluop_funct = 2'd2;

  typedef struct packed {
    logic       ir_write;
    logic       pc_inc;
    logic       pc_load;
    logic       pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } mc_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
//------------------------------------------------------------------------------
// Module   : mc_ctrl_decode
// Brief    : Combinational state-to-control-word table for mc_control.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mc_ctrl_decode
  import mc_pkg::*;
(
  input  mc_state_t state,
  input  logic      zero,
  output mc_ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write  = 1'b1;
        ctrl.pc_inc    = 1'b1;
        ctrl.alu_src_b = c_srcb_one;
      end
      // branch target is precomputed while the opcode is being decoded
      S_DECODE: ctrl.alu_src_b = c_srcb_imm_sl2;
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = c_srcb_b;
        ctrl.alu_op    = c_aluop_funct;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = c_srcb_imm;
        ctrl.alu_op    = c_aluop_add;
      end
      S_MEMRD: ctrl.mem_read = 1'b1;
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: ctrl.mem_write = 1'b1;
      S_IWB:   ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = c_srcb_b;
        ctrl.alu_op    = c_aluop_sub;
        ctrl.pc_load   = zero;
      end
      S_JUMP: begin
        ctrl.pc_load = 1'b1;
        ctrl.pc_src  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control.sv
//------------------------------------------------------------------------------
// Module   : mc_control
// Brief    : Multi-cycle MIPS control FSM with retired-instruction counter.
//            Optional MC_CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap to HALT.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mc_control
  import mc_pkg::*;
#(
  parameter int OP_W  = 6,
  parameter int FN_W  = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  opcode,
  input  logic [FN_W-1:0]  funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             pc_src,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             mem_write,
  output logic             mem_read,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  output logic             illegal_op,
`endif
  output logic [CNT_W-1:0] instr_count
);

  mc_state_t        r_state;
  mc_state_t        w_next;
  logic [CNT_W-1:0] r_count;
  mc_ctrl_t         w_ctrl;
  mc_ctrl_t         w_out;
  logic             w_unused_funct;

  // funct is consumed by the ALU control, not here
  assign w_unused_funct = ^funct;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          c_op_rtype:                  w_next = S_EXEC;
          c_op_lw, c_op_sw, c_op_addi: w_next = S_MEMADR;
          c_op_beq:                    w_next = S_BRANCH;
          c_op_j:                      w_next = S_JUMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:                     w_next = S_HALT;
`else
          default:                     w_next = S_FETCH;
`endif
        endcase
      end
      S_EXEC:   w_next = S_RWB;
      S_RWB:    w_next = S_FETCH;
      S_MEMADR: begin
        if (opcode == c_op_lw)      w_next = S_MEMRD;
        else if (opcode == c_op_sw) w_next = S_MEMWR;
        else                        w_next = S_IWB;
      end
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_IWB:    w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  // an instruction retires on the edge that returns the FSM to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_count <= '0;
    else if (w_next == S_FETCH) r_count <= r_count + CNT_W'(1);
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         r_illegal <= 1'b0;
    else if (r_state == S_DECODE && w_next == S_HALT) r_illegal <= 1'b1;
  end

  assign illegal_op = r_illegal;
`endif

  mc_ctrl_decode u_decode (
    .state (r_state),
    .zero  (zero),
    .ctrl  (w_ctrl)
  );

  // FETCH decodes to live strobes, so the whole word is masked during reset
  assign w_out = reset ? '0 : w_ctrl;

  assign ir_write    = w_out.ir_write;
  assign pc_inc      = w_out.pc_inc;
  assign pc_load     = w_out.pc_load;
  assign pc_src      = w_out.pc_src;
  assign reg_write   = w_out.reg_write;
  assign reg_dst     = w_out.reg_dst;
  assign mem_to_reg  = w_out.mem_to_reg;
  assign mem_write   = w_out.mem_write;
  assign mem_read    = w_out.mem_read;
  assign alu_src_a   = w_out.alu_src_a;
  assign alu_src_b   = w_out.alu_src_b;
  assign alu_op      = w_out.alu_op;
  assign state       = r_state;
  assign instr_count = r_count;

endmodule

`default_nettype wire
